// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU control types.
//   pipe_state_t : per-latch control word driven by the hazard controller
//                  ENABLE loads the latch, STALL holds it, NOP loads a bubble.
//   hzd_state_t  : states of the hazard controller FSM.
//   Also holds a few defaults and small helpers used by the controller.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'b00,
      PIPE_STALL  = 2'b01,
      PIPE_NOP    = 2'b10
   } pipe_state_t;

   typedef enum logic [1:0] {
      HZ_RUN,
      HZ_DWAIT,
      HZ_HALTED
   } hzd_state_t;

   // Defaults for the controller's widths.
   localparam int DEFAULT_CNT_W = 32;
   localparam int DEFAULT_REG_W = 5;

   // A data-memory access is outstanding when the MEM stage touches memory
   // and the dcache has not yet answered.
   function automatic logic dmemWaiting(input logic dren,
                                        input logic dwen,
                                        input logic hit);
      return (dren | dwen) & ~hit;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the controller's performance counters.
//   Counts up by one on each enabled cycle, sticks at all-ones, and holds
//   its value while frozen.
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active high, clears the count
//   inc    : count this cycle
//   freeze : hold the count regardless of inc
//   q      : current count, CNT_W bits
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             freeze,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic atMax;

   // Saturation point is all-ones; the counter never wraps back to zero.
   always_comb begin
      atMax = (q == {CNT_W{1'b1}});
   end

   // Count register: advances only when asked, not frozen and not saturated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (inc && !freeze && !atMax) begin
         q <= q + ONE;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central pipeline controller. Produces the control word for each of the
//   four pipeline latches (FD, DE, EM, MW) and the PC write enable from the
//   cache handshakes, the load-use operands, MEM-stage redirects and halt.
//   Keeps a RUN / DWAIT / HALTED FSM and two saturating performance counters.
// Ports
//   CLK, RST           : clock (rising edge), asynchronous active-high reset
//   ihit               : icache delivered an instruction this cycle
//   dhit               : dcache completed the MEM-stage access this cycle
//   m_dren, m_dwen     : MEM-stage instruction reads / writes data memory
//   m_redirect         : MEM stage resolved a taken branch or jump
//   e_memread, e_rd    : EX-stage instruction is a load, and its destination
//   d_rs, d_rt         : source registers of the DE-stage instruction
//   w_halt             : HALT instruction sits in the MW latch
//   pc_en              : PC loads its next value
//   fd/de/em/mw_state  : pipe_state_t control for each latch
//   halt               : high while the controller is HALTED
//   stall_cnt          : cycles with pc_en low while not halted (saturating)
//   flush_cnt          : redirects accepted (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int REG_W = DEFAULT_REG_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             m_dren,
   input  logic             m_dwen,
   input  logic             m_redirect,
   input  logic             e_memread,
   input  logic [REG_W-1:0] e_rd,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             w_halt,
   output logic             pc_en,
   output logic [1:0]       fd_state,
   output logic [1:0]       de_state,
   output logic [1:0]       em_state,
   output logic [1:0]       mw_state,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hzd_state_t  state;
   hzd_state_t  nextState;
   pipe_state_t fdCtrl;
   pipe_state_t deCtrl;
   pipe_state_t emCtrl;
   pipe_state_t mwCtrl;
   logic        pcEnable;
   logic        halted;
   logic        dmemPending;
   logic        loadUse;
   logic        redirectFire;

   // Hazard detection terms. A load into r0 never creates a dependency
   // because r0 is hard-wired to zero.
   always_comb begin
      dmemPending = dmemWaiting(m_dren, m_dwen, dhit);
      loadUse     = e_memread && (e_rd != '0) &&
                    ((e_rd == d_rs) || (e_rd == d_rt));
      halted      = (state == HZ_HALTED);
   end

   // FSM state register. Reset always lands in RUN, so a reset taken while
   // waiting on the dcache or while halted leaves no stall behind.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= HZ_RUN;
      end else begin
         state <= nextState;
      end
   end

   // FSM next state. DWAIT tracks an outstanding dcache access; HALTED is a
   // trap state left only through reset. A HALT reaching writeback wins over
   // every other transition.
   always_comb begin
      nextState = state;
      case (state)
         HZ_RUN: begin
            if (dmemPending) begin
               nextState = HZ_DWAIT;
            end
         end
         HZ_DWAIT: begin
            if (dhit) begin
               nextState = HZ_RUN;
            end
         end
         HZ_HALTED: begin
            nextState = HZ_HALTED;
         end
         default: begin
            nextState = HZ_RUN;
         end
      endcase
      if (w_halt) begin
         nextState = HZ_HALTED;
      end
   end

   // Latch control priority mux, first match wins. A redirect held behind a
   // dcache wait is not lost: EM stays stalled, so m_redirect is still high
   // on the dhit cycle and fires exactly once then. A redirect also ignores
   // ihit because fetch restarts from the new PC anyway.
   always_comb begin
      pcEnable     = 1'b1;
      fdCtrl       = PIPE_ENABLE;
      deCtrl       = PIPE_ENABLE;
      emCtrl       = PIPE_ENABLE;
      mwCtrl       = PIPE_ENABLE;
      redirectFire = 1'b0;
      if (halted) begin
         pcEnable = 1'b0;
         fdCtrl   = PIPE_STALL;
         deCtrl   = PIPE_STALL;
         emCtrl   = PIPE_STALL;
         mwCtrl   = PIPE_STALL;
      end else if (dmemPending) begin
         pcEnable = 1'b0;
         fdCtrl   = PIPE_STALL;
         deCtrl   = PIPE_STALL;
         emCtrl   = PIPE_STALL;
         mwCtrl   = PIPE_NOP;
      end else if (m_redirect) begin
         pcEnable     = 1'b1;
         fdCtrl       = PIPE_NOP;
         deCtrl       = PIPE_NOP;
         emCtrl       = PIPE_NOP;
         mwCtrl       = PIPE_ENABLE;
         redirectFire = 1'b1;
      end else if (loadUse) begin
         pcEnable = 1'b0;
         fdCtrl   = PIPE_STALL;
         deCtrl   = PIPE_NOP;
      end else if (!ihit) begin
         pcEnable = 1'b0;
         fdCtrl   = PIPE_NOP;
      end
   end

   // Drive the ports from the typed control values.
   always_comb begin
      pc_en    = pcEnable;
      fd_state = fdCtrl;
      de_state = deCtrl;
      em_state = emCtrl;
      mw_state = mwCtrl;
      halt     = halted;
   end

   // Stall cycles: any cycle the PC does not advance, frozen once halted.
   sat_counter #(
      .CNT_W (CNT_W)
   ) stallCounter (
      .clk    (CLK),
      .rst    (RST),
      .inc    (~pcEnable),
      .freeze (halted),
      .q      (stall_cnt)
   );

   // Accepted redirects: only cycles where the redirect actually flushed.
   sat_counter #(
      .CNT_W (CNT_W)
   ) flushCounter (
      .clk    (CLK),
      .rst    (RST),
      .inc    (redirectFire),
      .freeze (halted),
      .q      (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Self-checking bench for pipeline_hazard_ctrl built with 4-bit counters so
//   saturation is reachable. Directed scenarios use fixed expected values;
//   the random scenario uses a rule-table model of the controller.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam logic [1:0] EN = 2'b00;
   localparam logic [1:0] ST = 2'b01;
   localparam logic [1:0] NP = 2'b10;

   // Control vectors {pc_en, fd, de, em, mw} for each situation.
   localparam logic [8:0] CTRL_RUN   = {1'b1, EN, EN, EN, EN};
   localparam logic [8:0] CTRL_HALT  = {1'b0, ST, ST, ST, ST};
   localparam logic [8:0] CTRL_DWAIT = {1'b0, ST, ST, ST, NP};
   localparam logic [8:0] CTRL_REDIR = {1'b1, NP, NP, NP, EN};
   localparam logic [8:0] CTRL_LU    = {1'b0, ST, NP, EN, EN};
   localparam logic [8:0] CTRL_IMISS = {1'b0, NP, EN, EN, EN};

   logic       CLK;
   logic       RST;
   logic       ihit;
   logic       dhit;
   logic       m_dren;
   logic       m_dwen;
   logic       m_redirect;
   logic       e_memread;
   logic [4:0] e_rd;
   logic [4:0] d_rs;
   logic [4:0] d_rt;
   logic       w_halt;
   logic       pc_en;
   logic [1:0] fd_state;
   logic [1:0] de_state;
   logic [1:0] em_state;
   logic [1:0] mw_state;
   logic       halt;
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;

   logic [8:0] ctrlOut;
   assign ctrlOut = {pc_en, fd_state, de_state, em_state, mw_state};

   int nChecks;
   int nPassed;

   // Reference model state.
   logic       mHalted;
   logic [3:0] mStall;
   logic [3:0] mFlush;

   pipeline_hazard_ctrl #(
      .CNT_W (4),
      .REG_W (5)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ihit       (ihit),
      .dhit       (dhit),
      .m_dren     (m_dren),
      .m_dwen     (m_dwen),
      .m_redirect (m_redirect),
      .e_memread  (e_memread),
      .e_rd       (e_rd),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .w_halt     (w_halt),
      .pc_en      (pc_en),
      .fd_state   (fd_state),
      .de_state   (de_state),
      .em_state   (em_state),
      .mw_state   (mw_state),
      .halt       (halt),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop if something wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, got running required finished");
      $fatal(1, "[TB] watchdog");
   end

   // Expected control from the priority table of the controller.
   function automatic logic [8:0] modelCtrl();
      if (mHalted) return CTRL_HALT;
      if ((m_dren || m_dwen) && !dhit) return CTRL_DWAIT;
      if (m_redirect) return CTRL_REDIR;
      if (e_memread && e_rd != 5'd0 && (e_rd == d_rs || e_rd == d_rt)) return CTRL_LU;
      if (!ihit) return CTRL_IMISS;
      return CTRL_RUN;
   endfunction

   // Drive one cycle of inputs just after the falling edge.
   task automatic applyStimulus(input logic ih, input logic dh, input logic dr,
                                input logic dw, input logic rdr, input logic mr,
                                input logic [4:0] erd, input logic [4:0] rs,
                                input logic [4:0] rt, input logic wh);
      @(negedge CLK);
      ihit = ih; dhit = dh; m_dren = dr; m_dwen = dw; m_redirect = rdr;
      e_memread = mr; e_rd = erd; d_rs = rs; d_rt = rt; w_halt = wh;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   // Advance the model over the coming rising edge, then let the DUT take it.
   task automatic stepClock();
      logic [8:0] e;
      e = modelCtrl();
      if (!mHalted) begin
         if (!e[8] && mStall != 4'hF) mStall = mStall + 4'd1;
         if (e == CTRL_REDIR && mFlush != 4'hF) mFlush = mFlush + 4'd1;
      end
      if (w_halt) mHalted = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      @(negedge CLK);
      RST = 1'b1;
      ihit = 1'b1; dhit = 1'b0; m_dren = 1'b0; m_dwen = 1'b0; m_redirect = 1'b0;
      e_memread = 1'b0; e_rd = 5'd0; d_rs = 5'd0; d_rt = 5'd0; w_halt = 1'b0;
      mHalted = 1'b0; mStall = 4'd0; mFlush = 4'd0;
      #2;
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      ihit = 1'b1; dhit = 1'b0; m_dren = 1'b0; m_dwen = 1'b0; m_redirect = 1'b0;
      e_memread = 1'b0; e_rd = 5'd0; d_rs = 5'd0; d_rt = 5'd0; w_halt = 1'b0;
      mHalted = 1'b0; mStall = 4'd0; mFlush = 4'd0;
      #3;
      nChecks++;
      if ({halt, stall_cnt, flush_cnt} !== 9'd0)
         $display("[TB] FAIL reset_regs: got halt=%b stall=%0d flush=%0d required 0 0 0", halt, stall_cnt, flush_cnt);
      else nPassed++;
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL reset_ctrl: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      // Combinational outputs follow inputs even during reset.
      ihit = 1'b0;
      #1;
      nChecks++;
      if (ctrlOut !== CTRL_IMISS)
         $display("[TB] FAIL reset_ctrl_imiss: got %b required %b", ctrlOut, CTRL_IMISS);
      else nPassed++;
      @(negedge CLK);
      ihit = 1'b1;
      RST = 1'b0;
   endtask

   task automatic test_load_use();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_LU)
         $display("[TB] FAIL load_use_rs: got %b required %b", ctrlOut, CTRL_LU);
      else nPassed++;
      stepClock();
      nChecks++;
      if (stall_cnt !== 4'd1)
         $display("[TB] FAIL load_use_stall_cnt: got %0d required 1", stall_cnt);
      else nPassed++;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL load_use_r0: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      stepClock();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_LU)
         $display("[TB] FAIL load_use_rt: got %b required %b", ctrlOut, CTRL_LU);
      else nPassed++;
      stepClock();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL load_use_not_load: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      stepClock();
      nChecks++;
      if (stall_cnt !== 4'd2)
         $display("[TB] FAIL load_use_stall_total: got %0d required 2", stall_cnt);
      else nPassed++;
   endtask

   task automatic test_dmem_miss();
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         nChecks++;
         if (ctrlOut !== CTRL_DWAIT)
            $display("[TB] FAIL dmem_wait_ctrl[%0d]: got %b required %b", i, ctrlOut, CTRL_DWAIT);
         else nPassed++;
         stepClock();
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL dmem_hit_ctrl: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      stepClock();
      nChecks++;
      if (stall_cnt !== 4'd3)
         $display("[TB] FAIL dmem_stall_cnt: got %0d required 3", stall_cnt);
      else nPassed++;
   endtask

   task automatic test_redirect_during_miss();
      doReset();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         nChecks++;
         if (ctrlOut !== CTRL_DWAIT)
            $display("[TB] FAIL redir_wait_ctrl[%0d]: got %b required %b", i, ctrlOut, CTRL_DWAIT);
         else nPassed++;
         stepClock();
      end
      nChecks++;
      if (flush_cnt !== 4'd0)
         $display("[TB] FAIL redir_wait_flush: got %0d required 0", flush_cnt);
      else nPassed++;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_REDIR)
         $display("[TB] FAIL redir_fire_ctrl: got %b required %b", ctrlOut, CTRL_REDIR);
      else nPassed++;
      stepClock();
      applyIdle();
      stepClock();
      nChecks++;
      if ({stall_cnt, flush_cnt} !== {4'd2, 4'd1})
         $display("[TB] FAIL redir_wait_counts: got stall=%0d flush=%0d required 2 1", stall_cnt, flush_cnt);
      else nPassed++;
   endtask

   task automatic test_redirect_imiss();
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      nChecks++;
      if (ctrlOut !== CTRL_REDIR)
         $display("[TB] FAIL redir_imiss_ctrl: got %b required %b", ctrlOut, CTRL_REDIR);
      else nPassed++;
      stepClock();
      nChecks++;
      if ({stall_cnt, flush_cnt} !== {4'd0, 4'd1})
         $display("[TB] FAIL redir_imiss_counts: got stall=%0d flush=%0d required 0 1", stall_cnt, flush_cnt);
      else nPassed++;
   endtask

   task automatic test_halt();
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      nChecks++;
      if (ctrlOut !== CTRL_RUN || halt !== 1'b0)
         $display("[TB] FAIL halt_request_cycle: got ctrl=%b halt=%b required %b 0", ctrlOut, halt, CTRL_RUN);
      else nPassed++;
      stepClock();
      nChecks++;
      if (halt !== 1'b1)
         $display("[TB] FAIL halt_entered: got %b required 1", halt);
      else nPassed++;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], 1'b0, i[1], 1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 5'd2, 1'b0);
         nChecks++;
         if (ctrlOut !== CTRL_HALT)
            $display("[TB] FAIL halt_ctrl[%0d]: got %b required %b", i, ctrlOut, CTRL_HALT);
         else nPassed++;
         stepClock();
      end
      nChecks++;
      if ({halt, stall_cnt, flush_cnt} !== {1'b1, 4'd1, 4'd1})
         $display("[TB] FAIL halt_frozen: got halt=%b stall=%0d flush=%0d required 1 1 1", halt, stall_cnt, flush_cnt);
      else nPassed++;
      doReset();
      nChecks++;
      if ({halt, stall_cnt, flush_cnt} !== 9'd0)
         $display("[TB] FAIL halt_reset: got halt=%b stall=%0d flush=%0d required 0 0 0", halt, stall_cnt, flush_cnt);
      else nPassed++;
      applyIdle();
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL halt_after_reset_ctrl: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      stepClock();
      // Reset taken while waiting on the dcache must leave nothing behind.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      doReset();
      applyIdle();
      nChecks++;
      if (ctrlOut !== CTRL_RUN)
         $display("[TB] FAIL dwait_reset_ctrl: got %b required %b", ctrlOut, CTRL_RUN);
      else nPassed++;
      stepClock();
      nChecks++;
      if ({halt, stall_cnt} !== {1'b0, 4'd0})
         $display("[TB] FAIL dwait_reset_stall: got halt=%b stall=%0d required 0 0", halt, stall_cnt);
      else nPassed++;
   endtask

   task automatic test_saturation();
      int badCycles;
      doReset();
      badCycles = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         if (ctrlOut !== CTRL_IMISS) badCycles++;
         stepClock();
      end
      nChecks++;
      if (badCycles != 0)
         $display("[TB] FAIL imiss_ctrl: got %0d wrong cycles required 0", badCycles);
      else nPassed++;
      nChecks++;
      if (stall_cnt !== 4'd15)
         $display("[TB] FAIL stall_saturate: got %0d required 15", stall_cnt);
      else nPassed++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      nChecks++;
      if (stall_cnt !== 4'd15)
         $display("[TB] FAIL stall_stays_saturated: got %0d required 15", stall_cnt);
      else nPassed++;
   endtask

   task automatic test_random();
      int haltAge;
      logic [8:0] e;
      doReset();
      haltAge = 0;
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), $urandom_range(0, 79) == 0);
         e = modelCtrl();
         nChecks++;
         if (ctrlOut !== e)
            $display("[TB] FAIL random_ctrl[%0d]: got %b required %b", i, ctrlOut, e);
         else nPassed++;
         stepClock();
         nChecks++;
         if ({halt, stall_cnt, flush_cnt} !== {mHalted, mStall, mFlush})
            $display("[TB] FAIL random_regs[%0d]: got halt=%b stall=%0d flush=%0d required %b %0d %0d",
                     i, halt, stall_cnt, flush_cnt, mHalted, mStall, mFlush);
         else nPassed++;
         if (mHalted) haltAge++;
         if (haltAge > 4) begin
            doReset();
            haltAge = 0;
         end
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      nChecks = 0;
      nPassed = 0;
      test_reset();
      test_load_use();
      test_dmem_miss();
      test_redirect_during_miss();
      test_redirect_imiss();
      test_halt();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
